// File: rtl/wb_select_stage.sv
// Writeback select stage: picks the result source (alu, memory, pc link,
// upper immediate) and issues a one-cycle register-file write strobe.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready MEM-stage handshake (ready only while idle)
//   sel               source select: 00 alu, 01 mem, 10 pc link, 11 imm_hi
//   alu, mem_out      datapath operands
//   pc_p2, imm        link address and upper-immediate byte
//   mem_size/mem_sext/addr0  load size, sign-extend, byte lane
//   dest, we_in       destination register and write enable
//   mem_rdy           memory data valid this cycle
//   flush             discard in-flight result / block acceptance
//   wb_data/wb_dest/wb_we    register-file write port
//   busy, err, stall_cnt     wait status, sticky timeout, wait-cycle count
//
// WIDTH must be at least 16 so that both byte lanes of mem_out exist.

module wb_select_stage #(
    parameter int WIDTH   = 16,
    parameter int PCW     = 13,
    parameter int RW      = 3,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] alu,
    input  logic [WIDTH-1:0] mem_out,
    input  logic [PCW-1:0]   pc_p2,
    input  logic [7:0]       imm,
    input  logic             mem_size,
    input  logic             mem_sext,
    input  logic             addr0,
    input  logic [RW-1:0]    dest,
    input  logic             we_in,
    input  logic             mem_rdy,
    input  logic             flush,
    output logic [WIDTH-1:0] wb_data,
    output logic [RW-1:0]    wb_dest,
    output logic             wb_we,
    output logic             busy,
    output logic             err,
    output logic [15:0]      stall_cnt
);

    typedef enum logic [0:0] {
        S_IDLE,
        S_WAIT
    } state_t;

    // The counter value seen during the last permitted wait cycle.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t           state;
    logic [7:0]       wcnt;
    logic [RW-1:0]    dest_q;
    logic             we_q;

    logic             accept;
    logic             direct;
    logic [7:0]       lane;
    logic [15:0]      imm16;
    logic [WIDTH-1:0] mem_val;
    logic [WIDTH-1:0] src_val;

    assign in_ready = (state == S_IDLE);
    assign accept   = in_valid && in_ready && !flush;

    // A result completes on the accept edge unless it is a load whose
    // data has not arrived yet.
    assign direct   = (sel != 2'b01) || mem_rdy;

    assign lane     = addr0 ? mem_out[15:8] : mem_out[7:0];
    assign imm16    = {imm, 8'h00};

    always_comb begin
        mem_val = mem_out;
        if (mem_size) begin
            if (mem_sext) begin
                mem_val = {{(WIDTH-8){lane[7]}}, lane};
            end else begin
                mem_val = {{(WIDTH-8){1'b0}}, lane};
            end
        end
    end

    always_comb begin
        src_val = alu;
        unique case (sel)
            2'b00: src_val = alu;
            2'b01: src_val = mem_val;
            2'b10: src_val = WIDTH'(pc_p2);
            2'b11: src_val = WIDTH'(imm16);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wcnt      <= 8'd0;
            dest_q    <= '0;
            we_q      <= 1'b0;
            wb_data   <= '0;
            wb_dest   <= '0;
            wb_we     <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            stall_cnt <= 16'd0;
        end else begin
            wb_we <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (direct) begin
                            wb_data <= src_val;
                            wb_dest <= dest;
                            wb_we   <= we_in;
                        end else begin
                            state  <= S_WAIT;
                            busy   <= 1'b1;
                            wcnt   <= 8'd0;
                            dest_q <= dest;
                            we_q   <= we_in;
                        end
                    end
                end
                S_WAIT: begin
                    if (stall_cnt != 16'hFFFF) begin
                        stall_cnt <= stall_cnt + 16'd1;
                    end
                    // flush beats data arrival, data beats timeout
                    if (flush) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (mem_rdy) begin
                        wb_data <= mem_val;
                        wb_dest <= dest_q;
                        wb_we   <= we_q;
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                    end else if (wcnt == WAIT_LAST) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end else begin
                        wcnt <= wcnt + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_select_stage.sv
// Testbench for wb_select_stage: directed scenarios plus a randomized run
// against a transaction-level model of the writeback stage.

module tb_wb_select_stage;

    localparam int WIDTH   = 16;
    localparam int PCW     = 13;
    localparam int RW      = 3;
    localparam int TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       sel = 2'b00;
    logic [WIDTH-1:0] alu = '0;
    logic [WIDTH-1:0] mem_out = '0;
    logic [PCW-1:0]   pc_p2 = '0;
    logic [7:0]       imm = '0;
    logic             mem_size = 1'b0;
    logic             mem_sext = 1'b0;
    logic             addr0 = 1'b0;
    logic [RW-1:0]    dest = '0;
    logic             we_in = 1'b0;
    logic             mem_rdy = 1'b0;
    logic             flush = 1'b0;
    logic [WIDTH-1:0] wb_data;
    logic [RW-1:0]    wb_dest;
    logic             wb_we;
    logic             busy;
    logic             err;
    logic [15:0]      stall_cnt;

    int n_chk = 0;
    int n_err = 0;

    wb_select_stage #(
        .WIDTH(WIDTH), .PCW(PCW), .RW(RW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .alu(alu), .mem_out(mem_out),
        .pc_p2(pc_p2), .imm(imm),
        .mem_size(mem_size), .mem_sext(mem_sext), .addr0(addr0),
        .dest(dest), .we_in(we_in),
        .mem_rdy(mem_rdy), .flush(flush),
        .wb_data(wb_data), .wb_dest(wb_dest), .wb_we(wb_we),
        .busy(busy), .err(err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [15:0] load_val(input logic [15:0] mo,
                                             input logic sz, input logic sx,
                                             input logic a0);
        int b;
        if (!sz) return mo;
        b = a0 ? int'(mo) / 256 : int'(mo) % 256;
        if (sx && b >= 128) return 16'(b + 32'hFF00);
        return 16'(b);
    endfunction

    function automatic logic [15:0] pick(input logic [1:0] s);
        case (s)
            2'd0:    return alu;
            2'd1:    return load_val(mem_out, mem_size, mem_sext, addr0);
            2'd2:    return 16'(int'(pc_p2));
            default: return 16'(int'(imm) * 256);
        endcase
    endfunction

    bit          m_pend = 0;
    logic [2:0]  m_dest = '0;
    bit          m_we = 0;
    int          m_waited = 0;
    logic [15:0] e_data = '0;
    logic [2:0]  e_dest = '0;
    bit          e_we = 0;
    bit          e_err = 0;
    int          e_stall = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend = 0; m_waited = 0; m_we = 0; m_dest = '0;
            e_data = '0; e_dest = '0; e_we = 0; e_err = 0; e_stall = 0;
        end else begin
            e_we = 0;
            if (!m_pend) begin
                if (in_valid && !flush) begin
                    if (sel != 2'd1 || mem_rdy) begin
                        e_data = pick(sel); e_dest = dest; e_we = we_in;
                    end else begin
                        m_pend = 1; m_dest = dest; m_we = we_in; m_waited = 0;
                    end
                end
            end else begin
                m_waited++;
                if (e_stall < 65535) e_stall++;
                if (flush) begin
                    m_pend = 0;
                end else if (mem_rdy) begin
                    e_data = load_val(mem_out, mem_size, mem_sext, addr0);
                    e_dest = m_dest; e_we = m_we; m_pend = 0;
                end else if (m_waited == TIMEOUT) begin
                    m_pend = 0; e_err = 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("m_wb_data", 32'(wb_data), 32'(e_data));
        chk("m_wb_dest", 32'(wb_dest), 32'(e_dest));
        chk("m_wb_we", 32'(wb_we), 32'(e_we));
        chk("m_busy", 32'(busy), 32'(m_pend));
        chk("m_in_ready", 32'(in_ready), 32'(!m_pend));
        chk("m_err", 32'(err), 32'(e_err));
        chk("m_stall", 32'(stall_cnt), 32'(e_stall));
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_wb_data", 32'(wb_data), 32'h0);
        chk("rst_wb_we", 32'(wb_we), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ready", 32'(in_ready), 32'h1);
        chk("rst_stall", 32'(stall_cnt), 32'h0);
        rst_n = 1'b1;

        // alu path, single-cycle valid
        in_valid = 1; sel = 2'd0; alu = 16'h1234; dest = 3'd5; we_in = 1;
        @(negedge clk);
        chk("alu_data", 32'(wb_data), 32'h1234);
        chk("alu_dest", 32'(wb_dest), 32'h5);
        chk("alu_we", 32'(wb_we), 32'h1);
        in_valid = 0; alu = 16'hFFFF;
        @(negedge clk);
        chk("alu_we_drop", 32'(wb_we), 32'h0);
        chk("alu_hold", 32'(wb_data), 32'h1234);

        // pc link and upper immediate
        in_valid = 1; sel = 2'd2; pc_p2 = 13'h1FFF;
        @(negedge clk);
        chk("pc_data", 32'(wb_data), 32'h1FFF);
        sel = 2'd3; imm = 8'hA5;
        @(negedge clk);
        chk("imm_data", 32'(wb_data), 32'hA500);
        in_valid = 0;

        // flush while idle blocks acceptance
        in_valid = 1; sel = 2'd0; alu = 16'hBEEF; flush = 1;
        @(negedge clk);
        chk("flush_idle_we", 32'(wb_we), 32'h0);
        chk("flush_idle_data", 32'(wb_data), 32'hA500);
        in_valid = 0; flush = 0;

        // signed byte load, data after three low cycles
        in_valid = 1; sel = 2'd1; mem_size = 1; mem_sext = 1; addr0 = 1;
        mem_out = 16'h80FF; mem_rdy = 0; dest = 3'd2; we_in = 1;
        @(negedge clk);
        in_valid = 0;
        chk("ld_busy1", 32'(busy), 32'h1);
        chk("ld_ready1", 32'(in_ready), 32'h0);
        @(negedge clk);
        chk("ld_busy2", 32'(busy), 32'h1);
        chk("ld_stall2", 32'(stall_cnt), 32'h1);
        @(negedge clk);
        chk("ld_busy3", 32'(busy), 32'h1);
        chk("ld_stall3", 32'(stall_cnt), 32'h2);
        mem_rdy = 1;
        @(negedge clk);
        chk("ld_data", 32'(wb_data), 32'hFF80);
        chk("ld_we", 32'(wb_we), 32'h1);
        chk("ld_dest", 32'(wb_dest), 32'h2);
        chk("ld_stall", 32'(stall_cnt), 32'h3);
        chk("ld_idle", 32'(busy), 32'h0);
        mem_rdy = 0;

        // timeout
        in_valid = 1; sel = 2'd1; dest = 3'd6;
        @(negedge clk);
        in_valid = 0;
        for (int i = 1; i < TIMEOUT; i++) begin
            @(negedge clk);
            chk("to_no_we", 32'(wb_we), 32'h0);
        end
        chk("to_busy_last", 32'(busy), 32'h1);
        chk("to_err_early", 32'(err), 32'h0);
        @(negedge clk);
        chk("to_idle", 32'(busy), 32'h0);
        chk("to_err", 32'(err), 32'h1);
        chk("to_ready", 32'(in_ready), 32'h1);
        chk("to_we", 32'(wb_we), 32'h0);
        chk("to_stall", 32'(stall_cnt), 32'd18);

        // flush and data in the same wait cycle
        in_valid = 1; sel = 2'd1; dest = 3'd7;
        @(negedge clk);
        in_valid = 0; flush = 1; mem_rdy = 1; mem_size = 0; mem_out = 16'h1111;
        @(negedge clk);
        chk("fl_we", 32'(wb_we), 32'h0);
        chk("fl_ready", 32'(in_ready), 32'h1);
        chk("fl_data", 32'(wb_data), 32'hFF80);
        flush = 0; mem_rdy = 0;

        // asynchronous reset while waiting
        in_valid = 1; sel = 2'd1;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        chk("ar_busy_pre", 32'(busy), 32'h1);
        #2 rst_n = 0;
        #1;
        chk("ar_busy", 32'(busy), 32'h0);
        chk("ar_err", 32'(err), 32'h0);
        chk("ar_stall", 32'(stall_cnt), 32'h0);
        chk("ar_data", 32'(wb_data), 32'h0);
        chk("ar_ready", 32'(in_ready), 32'h1);
        #3 rst_n = 1;
        @(negedge clk);
        in_valid = 1; sel = 2'd0; alu = 16'h5A5A; dest = 3'd3; we_in = 1;
        @(negedge clk);
        chk("ar_next_data", 32'(wb_data), 32'h5A5A);
        chk("ar_next_dest", 32'(wb_dest), 32'h3);
        chk("ar_next_we", 32'(wb_we), 32'h1);
        in_valid = 0;

        // randomized traffic, phases with sparse and dense memory data
        for (int ph = 0; ph < 6; ph++) begin
            int rdy_pct;
            rdy_pct = (ph % 2 == 0) ? 10 : 60;
            for (int c = 0; c < 500; c++) begin
                @(negedge clk);
                in_valid = ($urandom_range(99) < 70);
                sel      = 2'($urandom_range(3));
                alu      = 16'($urandom);
                mem_out  = 16'($urandom);
                pc_p2    = 13'($urandom);
                imm      = 8'($urandom);
                mem_size = 1'($urandom);
                mem_sext = 1'($urandom);
                addr0    = 1'($urandom);
                dest     = 3'($urandom);
                we_in    = ($urandom_range(99) < 85);
                mem_rdy  = ($urandom_range(99) < rdy_pct);
                flush    = ($urandom_range(99) < 5);
            end
        end
        @(negedge clk);
        in_valid = 0; flush = 0; mem_rdy = 0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/wb_select_stage.md
WB_SELECT_STAGE -- requirements
Module: wb_select_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the datapath and writeback word width.
REQ-002 The block SHALL have parameter PCW, default 13, meaning the PC width, constrained to PCW <= WIDTH.
REQ-003 The block SHALL have parameter RW, default 3, meaning the register-index width.
REQ-004 The block SHALL have parameter TIMEOUT, default 15, meaning the maximum memory-wait cycles before abort (1..255).
REQ-005 The block SHALL have ports: clk in 1, rising-edge clock; rst_n in 1, reset, asynchronous and active-low.
REQ-006 The block SHALL have ports: in_valid in 1, MEM-stage result valid; in_ready out 1, stage can accept.
REQ-007 The block SHALL have ports: sel in 2, source select (00 alu, 01 mem, 10 pc link, 11 imm_hi).
REQ-008 The block SHALL have ports: alu in WIDTH; mem_out in WIDTH; pc_p2 in PCW; imm in 8, upper-immediate byte.
REQ-009 The block SHALL have ports: mem_size in 1 (0 word, 1 byte); mem_sext in 1; addr0 in 1, byte lane; dest in RW; we_in in 1.
REQ-010 The block SHALL have ports: mem_rdy in 1, memory data valid this cycle; flush in 1, discard in-flight result.
REQ-011 The block SHALL have ports: wb_data out WIDTH; wb_dest out RW; wb_we out 1, one-cycle regfile write strobe.
REQ-012 The block SHALL have ports: busy out 1, waiting on memory; err out 1, sticky timeout flag; stall_cnt out 16, saturating wait-cycle counter.

Function
REQ-013 Source values SHALL be: alu; mem-derived (REQ-014); {zeros, pc_p2} zero-extended to WIDTH; {imm, 8'h00} zero-extended to WIDTH when WIDTH > 16, otherwise the low WIDTH bits.
REQ-014 mem-derived SHALL be mem_out for mem_size=0; for mem_size=1 it SHALL be byte mem_out[15:8] if addr0=1, else mem_out[7:0], sign-extended if mem_sext=1, otherwise zero-extended.
REQ-015 The FSM SHALL have states IDLE and WAIT; in_ready SHALL be 1 only in IDLE.
REQ-016 Accept SHALL be in_valid && in_ready && !flush; on accept, dest, we_in, sel and the source operands SHALL be captured.
REQ-017 On accept with sel != 01, or sel == 01 with mem_rdy=1: at the next edge wb_data SHALL equal the selected source, wb_dest = dest, wb_we = we_in, and the state SHALL stay IDLE (latency 1).
REQ-018 On accept with sel == 01 and mem_rdy=0, the state SHALL go to WAIT and busy SHALL be 1.
REQ-019 In WAIT, mem_out/mem_size/mem_sext/addr0 SHALL be sampled on the first cycle with mem_rdy=1; that edge SHALL issue the write per REQ-017 and return to IDLE.
REQ-020 A wait counter SHALL count WAIT cycles; if it reaches TIMEOUT with mem_rdy still 0, the state SHALL go to IDLE, wb_we stays 0, and err SHALL be set (sticky until reset).
REQ-021 flush in WAIT SHALL return to IDLE with no write; flush in IDLE SHALL block acceptance that cycle.
REQ-022 When flush and mem_rdy are both 1 in WAIT, flush SHALL win.
REQ-023 wb_we SHALL be high for exactly one cycle per completed result; wb_data and wb_dest SHALL hold their last values otherwise.
REQ-024 stall_cnt SHALL increment each cycle in WAIT and saturate at 16'hFFFF.
REQ-025 Undefined inputs SHALL NOT occur: every sel code is decoded and no output latches combinationally.

Reset
REQ-026 While rst_n=0, regardless of clk: state SHALL be IDLE; wb_data=0, wb_dest=0, wb_we=0, busy=0, err=0, stall_cnt=0, wait counter=0.
REQ-027 Reset asserted in WAIT SHALL abandon the transaction without a write; the first accept after release SHALL behave as REQ-016.

Verification
REQ-028 sel=00, alu=16'h1234, dest=5, we_in=1, single-cycle in_valid -> next edge wb_data=16'h1234, wb_dest=5, wb_we=1 for one cycle.
REQ-029 sel=10, pc_p2=13'h1FFF -> wb_data=16'h1FFF; sel=11, imm=8'hA5 -> wb_data=16'hA500.
REQ-030 sel=01, mem_size=1, mem_sext=1, addr0=1, mem_out=16'h80FF, mem_rdy low for 3 cycles -> in_ready=0 and busy=1 for 3 cycles, stall_cnt=3, then wb_data=16'hFF80 with wb_we=1.
REQ-031 sel=01, mem_rdy held 0 -> after TIMEOUT(15) WAIT cycles: IDLE, err=1, wb_we never asserted.
REQ-032 In WAIT, flush=1 and mem_rdy=1 same cycle -> no write, in_ready=1 next cycle.
REQ-033 rst_n pulsed low mid-WAIT, asynchronous to clk -> all outputs 0 immediately; a subsequent sel=00 accept writes normally.
